legv8_decode_stage: RTL and testbench
=====================================

Name: legv8_decode_stage

Overview:
- Registered, flow-controlled LEGv8 decode stage that sits between instruction fetch and register read/execute.
- Buffers fetched instructions and their PCs in a parametrised FIFO and decodes the full B/BL/CB/D/R/I/MOV instruction subset.
- Presents one registered control/operand bundle per cycle with valid/ready handshakes on both sides.
- New over the combinational decoder: DATA_WIDTH immediate extension, BL link, CBNZ flag, MOVZ/MOVK shift, illegal-instruction flag, flush, backpressure.

Parameters:
- DATA_WIDTH, 64, width of the extended immediate and the PC.
- FIFO_DEPTH, 2, input queue entries (≥2, power of two).

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- flush  in  1  discard all queued and output-held instructions.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  queue can accept.
- in_instr  in  32  instruction word.
- in_pc  in  DATA_WIDTH  PC of in_instr.
- out_valid  out  1  bundle valid.
- out_ready  in  1  downstream consumes the bundle.
- out_pc  out  DATA_WIDTH  PC passthrough.
- register1, register2, write_register  out  5  Rn, Rm/Rt, Rd/Rt/X30.
- immediate  out  DATA_WIDTH  extended immediate.
- mov_shift  out  2  hw field, MOVZ/MOVK only.
- reg2loc, uncond_branch, branch, branch_nz, link, mem_read, mem_to_reg, mem_write, alu_src, reg_write, mov_keep, illegal  out  1 each  control signals.
- alu_op  out  2  00 add (mem), 01 pass/branch, 10 R/I function, 11 move.

Behaviour:
- Reset: FIFO empty, pointers and count 0. All outputs 0, including out_valid. in_ready is 1 in the cycle after reset deasserts.
- Push: in_valid & in_ready at edge k writes {in_instr, in_pc} to the tail.
- in_ready = (count < FIFO_DEPTH). It is registered-state only, with no combinational path from out_ready.
- Output register loads the decode of the FIFO head when (!out_valid | out_ready) and the FIFO is non-empty.
- Minimum latency: accepted at edge k → out_valid=1 after edge k+1.
- Full throughput of 1 instruction/cycle with out_ready held high.
- Bundle hold: while out_valid & !out_ready, all outputs hold stable.
- Simultaneous push and pop in one cycle: count unchanged, both pointers advance, pointers wrap modulo FIFO_DEPTH.
- Flush (priority over push/pop): at that edge, count is set to 0, out_valid is set to 0, and any in beat presented in the same cycle is dropped.
- reset behaves identically to flush and additionally zeroes all outputs.
- Decode, on instr[31:21] prefix:
  - B 000101: uncond_branch=1.
  - BL 100101: uncond_branch=1, link=1, reg_write=1, write_register=30.
  - Immediate for B/BL: sign-extended imm26.
- CBZ 10110100 / CBNZ 10110101:
  - branch=1, reg2loc=1, alu_op=01, register2=instr[4:0].
  - branch_nz=1 for CBNZ only.
  - Immediate: sign-extended imm19 = instr[23:5].
- LDUR 11111000010:
  - mem_read, mem_to_reg, reg_write, alu_src=1, alu_op=00.
  - register1=Rn, write_register=Rt.
  - Immediate: sign-extended imm9 = instr[20:12].
- STUR 11111000000:
  - mem_write, reg2loc, alu_src=1, alu_op=00.
  - register1=Rn, register2=Rt.
  - Immediate: sign-extended imm9.
- R-type ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000, EOR 11001010000:
  - reg_write=1, alu_op=10.
  - register1=Rn, register2=Rm, write_register=Rd.
- I-type ADDI 1001000100, SUBI 1101000100, ANDI 1001001000, ORRI 1011001000 (10-bit prefix):
  - alu_src=1, reg_write=1, alu_op=10.
  - Immediate: imm12 = instr[21:10], zero-extended.
- MOVZ 110100101 / MOVK 111100101 (9-bit prefix):
  - reg_write=1, alu_src=1, alu_op=11.
  - mov_shift=instr[22:21], immediate = zero-extended instr[20:5].
  - MOVK: mov_keep=1 and register1=Rd (old value is read).
- Any other encoding: illegal=1, all write/branch/mem enables 0, out_valid still 1 so the trap is delivered in order.
- Every control bit not listed for an opcode is 0 and every unused register field is 0, so there are no latched stale values.

Decomposition:
- Shared header legv8_defs.vh: opcode prefix constants, ALUOp codes, register number 30 (LINK_REG).
- Sub-module legv8_decode_comb: pure combinational instr → bundle.
- The stage wraps legv8_decode_comb with the FIFO and output register.

Test Plan:
- ADD X3,X1,X2 0x8B020023, out_ready=1 → next-cycle bundle: register1=1, register2=2, write_register=3, reg_write=1, alu_op=10, illegal=0.
- LDUR X5,[X2,#-8] 0xF85F8045 → mem_read=mem_to_reg=reg_write=alu_src=1, immediate=0xFFFF_FFFF_FFFF_FFF8. CBNZ 0xB5FFFFC9 → branch=branch_nz=1, register2=9, immediate=-2.
- BL #4 0x94000004 → link=1, reg_write=1, write_register=30, immediate=4. MOVK X7,#0xBEEF,LSL16 0xF2B7DDE7 → immediate=0xBEEF, mov_shift=01, mov_keep=1, register1=7.
- out_ready=0, push 4 back-to-back (DEPTH=2) → 3 accepted, in_ready=0 from the cycle after the 3rd. Release out_ready → in-order delivery with PCs intact; the 4th offer is accepted once in_ready returns.
- Flush with 2 queued plus an in beat offered in the same cycle → out_valid=0 next cycle, nothing delivered afterwards, in_ready=1.
- 0x00000000 → illegal=1, reg_write=mem_write=branch=0. Reset mid-stream → all outputs 0, queue empty.

Source files
------------

// File: rtl/legv8_decode_stage_pkg.sv
// rtl/legv8_decode_stage_pkg.sv - opcode prefixes, ALU op codes and control bundle type
package legv8_decode_stage_pkg;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,
    ALU_PASS = 2'b01,
    ALU_FUNC = 2'b10,
    ALU_MOVE = 2'b11
  } alu_op_t;

  localparam logic [4:0]  LINK_REG = 5'd30;

  localparam logic [5:0]  OP_B     = 6'b000101;
  localparam logic [5:0]  OP_BL    = 6'b100101;
  localparam logic [7:0]  OP_CBZ   = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ  = 8'b10110101;
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] OP_STUR  = 11'b11111000000;
  localparam logic [10:0] OP_ADD   = 11'b10001011000;
  localparam logic [10:0] OP_SUB   = 11'b11001011000;
  localparam logic [10:0] OP_AND   = 11'b10001010000;
  localparam logic [10:0] OP_ORR   = 11'b10101010000;
  localparam logic [10:0] OP_EOR   = 11'b11001010000;
  localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI  = 10'b1101000100;
  localparam logic [9:0]  OP_ANDI  = 10'b1001001000;
  localparam logic [9:0]  OP_ORRI  = 10'b1011001000;
  localparam logic [8:0]  OP_MOVZ  = 9'b110100101;
  localparam logic [8:0]  OP_MOVK  = 9'b111100101;

  typedef struct packed {
    logic    reg2loc;
    logic    uncond_branch;
    logic    branch;
    logic    branch_nz;
    logic    link;
    logic    mem_read;
    logic    mem_to_reg;
    logic    mem_write;
    logic    alu_src;
    logic    reg_write;
    logic    mov_keep;
    logic    illegal;
    alu_op_t alu_op;
  } ctrl_t;

endpackage

// File: rtl/legv8_decode_stage_if.sv
// rtl/legv8_decode_stage_if.sv - fetch-side and execute-side handshake bundle
interface legv8_decode_stage_if #(parameter int DATA_WIDTH = 64);
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           in_instr;
  logic [DATA_WIDTH-1:0] in_pc;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_pc;
  logic [4:0]            register1;
  logic [4:0]            register2;
  logic [4:0]            write_register;
  logic [DATA_WIDTH-1:0] immediate;
  logic [1:0]            mov_shift;
  logic                  reg2loc, uncond_branch, branch, branch_nz, link;
  logic                  mem_read, mem_to_reg, mem_write, alu_src, reg_write;
  logic                  mov_keep, illegal;
  logic [1:0]            alu_op;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, register1, register2, write_register,
           immediate, mov_shift, reg2loc, uncond_branch, branch, branch_nz, link,
           mem_read, mem_to_reg, mem_write, alu_src, reg_write, mov_keep, illegal, alu_op
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, register1, register2, write_register,
           immediate, mov_shift, reg2loc, uncond_branch, branch, branch_nz, link,
           mem_read, mem_to_reg, mem_write, alu_src, reg_write, mov_keep, illegal, alu_op
  );
endinterface

// File: rtl/legv8_decode_comb.sv
// rtl/legv8_decode_comb.sv - combinational LEGv8 instruction to control/operand bundle
module legv8_decode_comb
  import legv8_decode_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [31:0]           instr,
  output ctrl_t                 ctrl,
  output logic [4:0]            register1,
  output logic [4:0]            register2,
  output logic [4:0]            write_register,
  output logic [DATA_WIDTH-1:0] immediate,
  output logic [1:0]            mov_shift
);

  logic [4:0] rd, rn, rm;
  assign rd = instr[4:0];
  assign rn = instr[9:5];
  assign rm = instr[20:16];

  // decode longest prefixes first; everything unlisted for an opcode stays zero
  always_comb begin
    ctrl           = '0;
    ctrl.alu_op    = ALU_ADD;
    register1      = '0;
    register2      = '0;
    write_register = '0;
    immediate      = '0;
    mov_shift      = '0;
    if (instr[31:21] == OP_LDUR) begin
      ctrl.mem_read   = 1'b1;
      ctrl.mem_to_reg = 1'b1;
      ctrl.reg_write  = 1'b1;
      ctrl.alu_src    = 1'b1;
      register1       = rn;
      write_register  = rd;
      immediate       = {{(DATA_WIDTH-9){instr[20]}}, instr[20:12]};
    end else if (instr[31:21] == OP_STUR) begin
      ctrl.mem_write  = 1'b1;
      ctrl.reg2loc    = 1'b1;
      ctrl.alu_src    = 1'b1;
      register1       = rn;
      register2       = rd;
      immediate       = {{(DATA_WIDTH-9){instr[20]}}, instr[20:12]};
    end else if (instr[31:21] inside {OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_EOR}) begin
      ctrl.reg_write  = 1'b1;
      ctrl.alu_op     = ALU_FUNC;
      register1       = rn;
      register2       = rm;
      write_register  = rd;
    end else if (instr[31:22] inside {OP_ADDI, OP_SUBI, OP_ANDI, OP_ORRI}) begin
      ctrl.alu_src    = 1'b1;
      ctrl.reg_write  = 1'b1;
      ctrl.alu_op     = ALU_FUNC;
      register1       = rn;
      write_register  = rd;
      immediate       = {{(DATA_WIDTH-12){1'b0}}, instr[21:10]};
    end else if (instr[31:23] == OP_MOVZ || instr[31:23] == OP_MOVK) begin
      ctrl.reg_write  = 1'b1;
      ctrl.alu_src    = 1'b1;
      ctrl.alu_op     = ALU_MOVE;
      write_register  = rd;
      mov_shift       = instr[22:21];
      immediate       = {{(DATA_WIDTH-16){1'b0}}, instr[20:5]};
      if (instr[31:23] == OP_MOVK) begin
        ctrl.mov_keep = 1'b1;
        register1     = rd;
      end
    end else if (instr[31:24] == OP_CBZ || instr[31:24] == OP_CBNZ) begin
      ctrl.branch     = 1'b1;
      ctrl.branch_nz  = (instr[31:24] == OP_CBNZ);
      ctrl.reg2loc    = 1'b1;
      ctrl.alu_op     = ALU_PASS;
      register2       = rd;
      immediate       = {{(DATA_WIDTH-19){instr[23]}}, instr[23:5]};
    end else if (instr[31:26] == OP_B) begin
      ctrl.uncond_branch = 1'b1;
      immediate          = {{(DATA_WIDTH-26){instr[25]}}, instr[25:0]};
    end else if (instr[31:26] == OP_BL) begin
      ctrl.uncond_branch = 1'b1;
      ctrl.link          = 1'b1;
      ctrl.reg_write     = 1'b1;
      write_register     = LINK_REG;
      immediate          = {{(DATA_WIDTH-26){instr[25]}}, instr[25:0]};
    end else begin
      ctrl.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/legv8_decode_stage.sv
// rtl/legv8_decode_stage.sv - queued, registered LEGv8 decode stage with flush and backpressure
module legv8_decode_stage
  import legv8_decode_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 2
) (
  input logic                  clk,
  input logic                  reset,
  input logic                  flush,
  legv8_decode_stage_if.slave  bus
);

  localparam int              PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]  DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);

  logic [31:0]           q_instr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] q_pc    [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [PTR_W:0]        count;
  logic                  push, pop;

  ctrl_t                 dec_ctrl, out_ctrl;
  logic [4:0]            dec_r1, dec_r2, dec_wr, out_r1, out_r2, out_wr;
  logic [DATA_WIDTH-1:0] dec_imm, out_imm, out_pc;
  logic [1:0]            dec_shift, out_shift;
  logic                  out_valid;

  // in_ready depends on queue occupancy only, never on out_ready
  assign bus.in_ready = (count < DEPTH_CNT);
  assign push = bus.in_valid & bus.in_ready;
  assign pop  = (count != '0) & (!out_valid | bus.out_ready);

  legv8_decode_comb #(.DATA_WIDTH(DATA_WIDTH)) u_dec (
    .instr          (q_instr[rd_ptr]),
    .ctrl           (dec_ctrl),
    .register1      (dec_r1),
    .register2      (dec_r2),
    .write_register (dec_wr),
    .immediate      (dec_imm),
    .mov_shift      (dec_shift)
  );

  // queue storage: writes land at the tail; contents beyond count are don't-care
  always_ff @(posedge clk) begin
    if (push && !flush && !reset) begin
      q_instr[wr_ptr] <= bus.in_instr;
      q_pc[wr_ptr]    <= bus.in_pc;
    end
  end

  // queue pointers and occupancy; flush and reset empty the queue and drop any in beat
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // output register: loads the decoded head when empty or being consumed, holds under stall
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
      out_r1    <= '0;
      out_r2    <= '0;
      out_wr    <= '0;
      out_imm   <= '0;
      out_shift <= '0;
      out_pc    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (pop) begin
      out_valid <= 1'b1;
      out_ctrl  <= dec_ctrl;
      out_r1    <= dec_r1;
      out_r2    <= dec_r2;
      out_wr    <= dec_wr;
      out_imm   <= dec_imm;
      out_shift <= dec_shift;
      out_pc    <= q_pc[rd_ptr];
    end else if (bus.out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign bus.out_valid      = out_valid;
  assign bus.out_pc         = out_pc;
  assign bus.register1      = out_r1;
  assign bus.register2      = out_r2;
  assign bus.write_register = out_wr;
  assign bus.immediate      = out_imm;
  assign bus.mov_shift      = out_shift;
  assign bus.reg2loc        = out_ctrl.reg2loc;
  assign bus.uncond_branch  = out_ctrl.uncond_branch;
  assign bus.branch         = out_ctrl.branch;
  assign bus.branch_nz      = out_ctrl.branch_nz;
  assign bus.link           = out_ctrl.link;
  assign bus.mem_read       = out_ctrl.mem_read;
  assign bus.mem_to_reg     = out_ctrl.mem_to_reg;
  assign bus.mem_write      = out_ctrl.mem_write;
  assign bus.alu_src        = out_ctrl.alu_src;
  assign bus.reg_write      = out_ctrl.reg_write;
  assign bus.mov_keep       = out_ctrl.mov_keep;
  assign bus.illegal        = out_ctrl.illegal;
  assign bus.alu_op         = out_ctrl.alu_op;

endmodule

// File: tb/tb_legv8_decode_stage.sv
// tb/tb_legv8_decode_stage.sv - table-driven scoreboard bench for the decode stage
module tb_legv8_decode_stage;

  typedef struct packed {
    logic [63:0] pc;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [4:0]  wr;
    logic [63:0] imm;
    logic [1:0]  sh;
    logic [1:0]  aop;
    logic [11:0] ctl;
  } bundle_t;

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [4:0]  wr;
    logic [63:0] imm;
    logic [1:0]  sh;
    logic [1:0]  aop;
    logic [11:0] ctl;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  always #5 clk = ~clk;

  legv8_decode_stage_if #(.DATA_WIDTH(64)) bus ();

  legv8_decode_stage #(.DATA_WIDTH(64), .FIFO_DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  int      n_checks = 0;
  int      n_fail   = 0;
  bundle_t sb[$];
  vec_t    vecs[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_checks);
    $fatal(1, "watchdog");
  end

  // ctl order: reg2loc uncond branch branch_nz link mem_read mem_to_reg mem_write alu_src reg_write mov_keep illegal
  function automatic bundle_t actual();
    bundle_t b;
    b.pc  = bus.out_pc;
    b.r1  = bus.register1;
    b.r2  = bus.register2;
    b.wr  = bus.write_register;
    b.imm = bus.immediate;
    b.sh  = bus.mov_shift;
    b.aop = bus.alu_op;
    b.ctl = {bus.reg2loc, bus.uncond_branch, bus.branch, bus.branch_nz, bus.link, bus.mem_read,
             bus.mem_to_reg, bus.mem_write, bus.alu_src, bus.reg_write, bus.mov_keep, bus.illegal};
    return b;
  endfunction

  function automatic bundle_t expect_of(input int idx, input logic [63:0] pc);
    bundle_t b;
    b.pc  = pc;
    b.r1  = vecs[idx].r1;
    b.r2  = vecs[idx].r2;
    b.wr  = vecs[idx].wr;
    b.imm = vecs[idx].imm;
    b.sh  = vecs[idx].sh;
    b.aop = vecs[idx].aop;
    b.ctl = vecs[idx].ctl;
    return b;
  endfunction

  function automatic void add(input logic [31:0] instr, input logic [4:0] r1, input logic [4:0] r2,
                              input logic [4:0] wr, input logic [63:0] imm, input logic [1:0] sh,
                              input logic [1:0] aop, input logic [11:0] ctl);
    vec_t v;
    v.instr = instr; v.r1 = r1; v.r2 = r2; v.wr = wr;
    v.imm = imm; v.sh = sh; v.aop = aop; v.ctl = ctl;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // one cycle: drive at negedge, sample handshakes 1ns later, let the posedge happen
  task automatic step(input logic v, input int idx, input logic [63:0] pc, input logic rdy,
                      input logic fl, input logic rs, output logic acc);
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_instr  = vecs[idx].instr;
    bus.in_pc     = pc;
    bus.out_ready = rdy;
    flush         = fl;
    reset         = rs;
    #1;
    acc = v && bus.in_ready && !fl && !rs;
    if (!fl && !rs && bus.out_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out: out_valid=1 pc=%h with nothing expected", bus.out_pc);
      end else begin
        check("bundle", actual(), sb[0]);
        if (rdy) void'(sb.pop_front());
      end
    end
    if (acc) sb.push_back(expect_of(idx, pc));
    if (fl || rs) sb.delete();
    @(posedge clk);
  endtask

  task automatic drain(input string name);
    logic acc;
    for (int c = 0; c < 30 && sb.size() != 0; c++) step(1'b0, 0, 64'h0, 1'b1, 1'b0, 1'b0, acc);
    check(name, sb.size(), 0);
  endtask

  initial begin
    logic        acc;
    int          n_acc;
    int          idx;
    int          done;
    logic [63:0] pc;

    add(32'h8B020023, 5'd1,  5'd2,  5'd3,  64'h0,                 2'd0, 2'b10, 12'h004); // ADD X3,X1,X2
    add(32'hF85F8045, 5'd2,  5'd0,  5'd5,  64'hFFFFFFFFFFFFFFF8,  2'd0, 2'b00, 12'h06C); // LDUR X5,[X2,#-8]
    add(32'hB5FFFFC9, 5'd0,  5'd9,  5'd0,  64'hFFFFFFFFFFFFFFFE,  2'd0, 2'b01, 12'hB00); // CBNZ X9,-2
    add(32'h94000004, 5'd0,  5'd0,  5'd30, 64'h4,                 2'd0, 2'b00, 12'h484); // BL #4
    add(32'hF2B7DDE7, 5'd7,  5'd0,  5'd7,  64'hBEEF,              2'd1, 2'b11, 12'h00E); // MOVK X7,#0xBEEF,LSL16
    add(32'h00000000, 5'd0,  5'd0,  5'd0,  64'h0,                 2'd0, 2'b00, 12'h001); // illegal
    add(32'hF80100C4, 5'd6,  5'd4,  5'd0,  64'h10,                2'd0, 2'b00, 12'h818); // STUR X4,[X6,#16]
    add(32'h17FFFFFF, 5'd0,  5'd0,  5'd0,  64'hFFFFFFFFFFFFFFFF,  2'd0, 2'b00, 12'h400); // B -1
    add(32'hB4000103, 5'd0,  5'd3,  5'd0,  64'h8,                 2'd0, 2'b01, 12'hA00); // CBZ X3,+8
    add(32'hCB0B0149, 5'd10, 5'd11, 5'd9,  64'h0,                 2'd0, 2'b10, 12'h004); // SUB X9,X10,X11
    add(32'h913FFC41, 5'd2,  5'd0,  5'd1,  64'hFFF,               2'd0, 2'b10, 12'h00C); // ADDI X1,X2,#0xFFF
    add(32'hD2F00002, 5'd0,  5'd0,  5'd2,  64'h8000,              2'd3, 2'b11, 12'h00C); // MOVZ X2,#0x8000,LSL48
    add(32'h8B200000, 5'd0,  5'd0,  5'd0,  64'h0,                 2'd0, 2'b00, 12'h001); // near-miss of ADD
    add(32'hCA000000, 5'd0,  5'd0,  5'd0,  64'h0,                 2'd0, 2'b10, 12'h004); // EOR X0,X0,X0

    bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0; bus.out_ready = 1'b0;
    flush = 1'b0; reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_bundle", actual(), '0);
    check("reset_out_valid", bus.out_valid, 1'b0);
    check("reset_in_ready", bus.in_ready, 1'b1);

    step(1'b1, 0, 64'h0000_0000_0040_0000, 1'b0, 1'b0, 1'b0, acc);
    check("lat_accept", acc, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    check("lat_edge_k", bus.out_valid, 1'b0);
    @(negedge clk);
    #1;
    check("lat_edge_k1", bus.out_valid, 1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      step(1'b1, i, 64'h0000_0000_0040_1000 + 64'(4 * i), 1'b1, 1'b0, 1'b0, acc);
      check("throughput_accept", acc, 1'b1);
    end
    drain("table_drain");

    done = 0;
    idx  = 0;
    pc   = {$urandom, $urandom};
    for (int c = 0; c < 600 && done < 40; c++) begin
      step(1'($urandom_range(0, 1)), idx, pc, 1'($urandom_range(0, 1)), 1'b0, 1'b0, acc);
      if (acc) begin
        done++;
        idx = $urandom_range(0, vecs.size() - 1);
        pc  = {$urandom, $urandom};
      end
    end
    check("random_accepted", done, 40);
    drain("random_drain");

    n_acc = 0;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, k, 64'h0000_0000_0050_0000 + 64'(4 * k), 1'b0, 1'b0, 1'b0, acc);
      if (acc) n_acc++;
    end
    #1;
    check("bp_accepted", n_acc, 3);
    check("bp_in_ready", bus.in_ready, 1'b0);
    acc = 1'b0;
    for (int c = 0; c < 10 && !acc; c++)
      step(1'b1, 3, 64'h0000_0000_0050_000C, 1'b1, 1'b0, 1'b0, acc);
    check("bp_fourth_accepted", acc, 1'b1);
    drain("bp_drain");

    step(1'b1, 4, 64'h0000_0000_0060_0000, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, 5, 64'h0000_0000_0060_0004, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, 6, 64'h0000_0000_0060_0008, 1'b0, 1'b1, 1'b0, acc);
    #1;
    check("flush_out_valid", bus.out_valid, 1'b0);
    check("flush_in_ready", bus.in_ready, 1'b1);
    for (int c = 0; c < 5; c++) begin
      step(1'b0, 0, 64'h0, 1'b1, 1'b0, 1'b0, acc);
      #1;
      check("flush_silent", bus.out_valid, 1'b0);
    end

    step(1'b1, 1, 64'h0000_0000_0070_0000, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, 2, 64'h0000_0000_0070_0004, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, 3, 64'h0000_0000_0070_0008, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, 4, 64'h0000_0000_0070_000C, 1'b1, 1'b0, 1'b1, acc);
    #1;
    check("midreset_bundle", actual(), '0);
    check("midreset_out_valid", bus.out_valid, 1'b0);
    check("midreset_in_ready", bus.in_ready, 1'b1);
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 0, 64'h0, 1'b1, 1'b0, 1'b0, acc);
      #1;
      check("midreset_silent", bus.out_valid, 1'b0);
    end

    step(1'b1, 2, 64'h0000_0000_0080_0000, 1'b1, 1'b0, 1'b0, acc);
    check("post_reset_accept", acc, 1'b1);
    drain("post_reset_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
